// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I main controller with req/ready memory handshake.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_control_fsm #(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      instr_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             iord_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             pc_write_cond_o,
   output logic [1:0]       pc_src_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_write_o,
   output logic [1:0]       wb_sel_o,
   output logic             illegal_o,
   output logic             mem_err_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_cnt_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
      ALU_WB = 4'd4, ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7,
      MEM_WR = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11
   } state_t;
   localparam int WW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          tmo;
   logic [6:0]    opcode;
   assign opcode = instr_i[6:0];
   assign tmo = (TIMEOUT_CYC != 0) && (wait_q == WW'(TIMEOUT_CYC));
   assign state_o = rst_i ? 4'd0 : state_q;
   always_comb begin
      state_d = state_q;
      mem_req_o = 1'b0;
      mem_we_o = 1'b0;
      iord_o = 1'b0;
      ir_write_o = 1'b0;
      pc_write_o = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_src_o = 2'b00;
      alu_src_a_o = 2'b00;
      alu_src_b_o = 2'b00;
      alu_op_o = 2'b00;
      reg_write_o = 1'b0;
      wb_sel_o = 2'b00;
      illegal_o = 1'b0;
      mem_err_o = 1'b0;
      if (!rst_i) begin
         case (state_q)
            FETCH: begin
               if (tmo) begin
                  mem_err_o = 1'b1;
                  state_d = FETCH;
               end else begin
                  mem_req_o = 1'b1;
                  alu_src_b_o = 2'b10;
                  ir_write_o = mem_ready_i;
                  pc_write_o = mem_ready_i;
                  state_d = mem_ready_i ? DECODE : FETCH;
               end
            end
            DECODE: begin
               alu_src_a_o = 2'b10;
               alu_src_b_o = 2'b01;
               case (opcode)
                  7'b0110011: state_d = EXEC_R;
                  7'b0010011: state_d = EXEC_I;
                  7'b0000011, 7'b0100011: state_d = ADDR;
                  7'b1100011: state_d = BRANCH;
                  7'b1101111: state_d = JAL;
                  7'b1100111: state_d = JALR;
                  default: begin
                     illegal_o = 1'b1;
                     state_d = FETCH;
                  end
               endcase
            end
            EXEC_R: begin
               alu_src_a_o = 2'b01;
               alu_op_o = 2'b10;
               state_d = ALU_WB;
            end
            EXEC_I: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b01;
               alu_op_o = 2'b11;
               state_d = ALU_WB;
            end
            ALU_WB: begin
               reg_write_o = 1'b1;
               state_d = FETCH;
            end
            ADDR: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b01;
               state_d = (opcode == 7'b0000011) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               if (tmo) begin
                  mem_err_o = 1'b1;
                  state_d = FETCH;
               end else begin
                  mem_req_o = 1'b1;
                  iord_o = 1'b1;
                  state_d = mem_ready_i ? MEM_WB : MEM_RD;
               end
            end
            MEM_WB: begin
               reg_write_o = 1'b1;
               wb_sel_o = 2'b01;
               state_d = FETCH;
            end
            MEM_WR: begin
               if (tmo) begin
                  mem_err_o = 1'b1;
                  state_d = FETCH;
               end else begin
                  mem_req_o = 1'b1;
                  mem_we_o = 1'b1;
                  iord_o = 1'b1;
                  state_d = mem_ready_i ? FETCH : MEM_WR;
               end
            end
            BRANCH: begin
               alu_src_a_o = 2'b01;
               alu_op_o = 2'b01;
               pc_write_cond_o = 1'b1;
               pc_src_o = 2'b01;
               state_d = FETCH;
            end
            JAL: begin
               pc_write_o = 1'b1;
               pc_src_o = 2'b01;
               reg_write_o = 1'b1;
               wb_sel_o = 2'b10;
               state_d = FETCH;
            end
            JALR: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b01;
               pc_write_o = 1'b1;
               reg_write_o = 1'b1;
               wb_sel_o = 2'b10;
               state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end
   // Wait counter runs only while a request is outstanding, so any non-request cycle clears it.
   assign wait_d = (TIMEOUT_CYC != 0 && mem_req_o && !mem_ready_i) ? wait_q + 1'b1 : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FETCH;
         wait_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q <= wait_d;
      end
   end
`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d, cycle_cnt_q, cycle_cnt_d;
   logic             retire;
   // A timed-out MEM_WR drops req, which keeps it from counting as retired.
   assign retire = (state_d == FETCH) &&
                   ((state_q inside {ALU_WB, MEM_WB, BRANCH, JAL, JALR, DECODE}) ||
                    (state_q == MEM_WR && mem_req_o));
   assign instr_cnt_d = instr_cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
   assign cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_cnt_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end
   assign instr_cnt_o = rst_i ? '0 : instr_cnt_q;
   assign cycle_cnt_o = rst_i ? '0 : cycle_cnt_q;
`else
   assign instr_cnt_o = '0;
   assign cycle_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven cycle-by-cycle check of the multi-cycle controller.
module tb_mc_control_fsm;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_JAL  = 32'h0080006F;
   localparam logic [31:0] I_JALR = 32'h00008067;
   localparam logic [31:0] I_ILL  = 32'h0000007F;
`ifdef MC_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        rdy;
      logic        ret;
      logic [22:0] exp;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] instr_i = I_ADD;
   logic        mem_ready_i = 1'b0;
   logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o;
   logic [1:0]  pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, wb_sel_o;
   logic        reg_write_o, illegal_o, mem_err_o;
   logic [3:0]  state_o;
   logic [31:0] instr_cnt_o, cycle_cnt_o;
   logic [22:0] act;
   vec_t        v[$];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] cyc_m = 0;
   logic [31:0] ins_m = 0;
   always #5 clk = ~clk;
   mc_control_fsm #(.CNT_W(32), .TIMEOUT_CYC(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .mem_ready_i(mem_ready_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
      .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
      .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .alu_op_o(alu_op_o), .reg_write_o(reg_write_o), .wb_sel_o(wb_sel_o),
      .illegal_o(illegal_o), .mem_err_o(mem_err_o), .state_o(state_o),
      .instr_cnt_o(instr_cnt_o), .cycle_cnt_o(cycle_cnt_o)
   );
   assign act = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
                 pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, wb_sel_o,
                 illegal_o, mem_err_o, state_o};
   function automatic logic [22:0] mk(input logic [3:0] st, input logic req, we, iord, irw, pcw, pcwc,
                                      input logic [1:0] pcs, a, b, op, input logic rw,
                                      input logic [1:0] wb, input logic ill, err);
      return {req, we, iord, irw, pcw, pcwc, pcs, a, b, op, rw, wb, ill, err, st};
   endfunction
   task automatic add(input logic rst, input logic [31:0] instr, input logic rdy, input logic ret,
                      input logic [22:0] exp);
      vec_t e;
      e.rst = rst; e.instr = instr; e.rdy = rdy; e.ret = ret; e.exp = exp;
      v.push_back(e);
   endtask
   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
   endtask
   initial begin
      logic [22:0] f_rdy, f_wait, dec, dec_ill, exr, exi, awb, addr, mrd, mwb, mwr, br, jal, jalr, tmo;
      int n;
      f_rdy   = mk(0, 1,0,0,1,1,0, 2'd0,2'd0,2'd2,2'd0, 0,2'd0, 0,0);
      f_wait  = mk(0, 1,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,2'd0, 0,0);
      dec     = mk(1, 0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, 0,2'd0, 0,0);
      dec_ill = mk(1, 0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, 0,2'd0, 1,0);
      exr     = mk(2, 0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd2, 0,2'd0, 0,0);
      exi     = mk(3, 0,0,0,0,0,0, 2'd0,2'd1,2'd1,2'd3, 0,2'd0, 0,0);
      awb     = mk(4, 0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd0, 0,0);
      addr    = mk(5, 0,0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0, 0,2'd0, 0,0);
      mrd     = mk(6, 1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 0,0);
      mwb     = mk(7, 0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd1, 0,0);
      mwr     = mk(8, 1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 0,0);
      br      = mk(9, 0,0,0,0,0,1, 2'd1,2'd1,2'd0,2'd1, 0,2'd0, 0,0);
      jal     = mk(10,0,0,0,0,1,0, 2'd1,2'd0,2'd0,2'd0, 1,2'd2, 0,0);
      jalr    = mk(11,0,0,0,0,1,0, 2'd0,2'd1,2'd1,2'd0, 1,2'd2, 0,0);
      tmo     = mk(0, 0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 0,1);
      add(1, I_ADD, 1, 0, '0); add(1, I_ADD, 1, 0, '0);
      add(0, I_ADD, 1, 0, f_rdy); add(0, I_ADD, 1, 0, dec); add(0, I_ADD, 1, 0, exr); add(0, I_ADD, 1, 1, awb);
      add(0, I_ADDI, 0, 0, f_wait); add(0, I_ADDI, 1, 0, f_rdy); add(0, I_ADDI, 1, 0, dec);
      add(0, I_ADDI, 1, 0, exi); add(0, I_ADDI, 1, 1, awb);
      add(0, I_LW, 1, 0, f_rdy); add(0, I_LW, 1, 0, dec); add(0, I_LW, 1, 0, addr);
      for (int i = 0; i < 3; i++) add(0, I_LW, 0, 0, mrd);
      add(0, I_LW, 1, 0, mrd); add(0, I_LW, 0, 1, mwb);
      add(0, I_SW, 1, 0, f_rdy); add(0, I_SW, 0, 0, dec); add(0, I_SW, 0, 0, addr);
      add(0, I_SW, 0, 0, mwr); add(0, I_SW, 1, 1, mwr);
      add(0, I_BEQ, 1, 0, f_rdy); add(0, I_BEQ, 1, 0, dec); add(0, I_BEQ, 1, 1, br);
      add(0, I_JAL, 1, 0, f_rdy); add(0, I_JAL, 1, 0, dec); add(0, I_JAL, 1, 1, jal);
      add(0, I_JALR, 1, 0, f_rdy); add(0, I_JALR, 1, 0, dec); add(0, I_JALR, 1, 1, jalr);
      add(0, I_ILL, 1, 0, f_rdy); add(0, I_ILL, 1, 1, dec_ill);
      for (int i = 0; i < 4; i++) add(0, I_ILL, 0, 0, f_wait);
      add(0, I_ILL, 1, 0, tmo); add(0, I_ILL, 0, 0, f_wait);
      add(0, I_LW, 1, 0, f_rdy); add(0, I_LW, 1, 0, dec); add(0, I_LW, 1, 0, addr); add(0, I_LW, 0, 0, mrd);
      for (int i = 0; i < 3; i++) add(1, I_LW, 1, 0, '0);
      add(0, I_LW, 0, 0, f_wait);
      foreach (v[i]) begin
         @(negedge clk);
         rst_i = v[i].rst; instr_i = v[i].instr; mem_ready_i = v[i].rdy;
         #1;
         chk($sformatf("row%0d outputs", i), {9'd0, act}, {9'd0, v[i].exp});
         chk($sformatf("row%0d instr_cnt", i), instr_cnt_o, (PERF && !v[i].rst) ? ins_m : 32'd0);
         chk($sformatf("row%0d cycle_cnt", i), cycle_cnt_o, (PERF && !v[i].rst) ? cyc_m : 32'd0);
         if (v[i].rst) begin
            cyc_m = 0; ins_m = 0;
         end else begin
            cyc_m++; ins_m += {31'd0, v[i].ret};
         end
      end
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0; mem_ready_i = 1'b0;
      n = 0;
      #1;
      while (!mem_err_o && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("timeout_wait_cycles", n, 4);
      chk("timeout_no_req", {31'd0, mem_req_o}, 32'd0);
      chk("timeout_instr_cnt", instr_cnt_o, 32'd0);
      @(negedge clk);
      #1;
      chk("timeout_refetch_req", {31'd0, mem_req_o}, 32'd1);
      chk("timeout_err_pulse", {31'd0, mem_err_o}, 32'd0);
      chk("timeout_cycle_cnt", cycle_cnt_o, PERF ? 32'd5 : 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
